fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 2: fetch-queue entries, power of two, minimum 2.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  instruction-memory request valid.
REQ-006 imem_addr  out  32  request address, always word-aligned.
REQ-007 imem_gnt  in  1  request accepted this cycle (transfer when imem_req && imem_gnt).
REQ-008 imem_rvalid  in  1  response valid; responses in order, at least 1 cycle after grant.
REQ-009 imem_rdata  in  32  response instruction word.
REQ-010 redirect_valid  in  1  decode-stage redirect (predictor target differs from pc+4, predict fail, or exception).
REQ-011 redirect_pc  in  32  new fetch address.
REQ-012 if_valid  out  1  fetched instruction available to decode.
REQ-013 if_pc  out  32  pc of the head instruction.
REQ-014 if_instr  out  32  head instruction word.
REQ-015 id_ready  in  1  decode accepts (low = stall); transfer when if_valid && id_ready.

Function
REQ-016 SHALL implement states BOOT, RUN and DRAIN. BOOT lasts exactly one cycle after reset release, with no request, then moves to RUN.
REQ-017 In RUN, imem_req SHALL be asserted when (queue count + outstanding) < QUEUE_DEPTH; imem_addr SHALL equal the fetch pc.
REQ-018 On a grant, fetch pc SHALL advance by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0) and outstanding SHALL increment.
REQ-019 imem_rvalid SHALL decrement outstanding and push {pc, instr} into the queue, unless the drop counter is nonzero, in which case the response is discarded and the drop counter decrements.
REQ-020 Queue push and pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-021 if_valid SHALL equal (queue not empty) && !redirect_valid; if_pc and if_instr SHALL reflect the queue head.
REQ-022 On redirect_valid:
- queue flushed next cycle;
- fetch pc <= {redirect_pc[31:2], 2'b00};
- drop counter <= outstanding + (imem_req && imem_gnt) - imem_rvalid;
- outstanding follows the same arithmetic;
- next state DRAIN if the new drop counter is nonzero, else RUN.
REQ-023 In DRAIN, imem_req SHALL be low. The state SHALL return to RUN in the cycle after the drop counter reaches 0.
REQ-024 A redirect during DRAIN SHALL overwrite fetch pc and recompute the drop counter by the same rule.
REQ-025 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-026 A redirect SHALL take priority over id_ready, push and grant bookkeeping. A grant in that cycle counts as stale.
REQ-027 Outstanding and drop counters SHALL be sized to hold QUEUE_DEPTH without overflow.

Reset
REQ-028 rst SHALL set the following; reset mid-operation SHALL discard in-flight responses by the same values:
- state BOOT;
- fetch pc RESET_PC;
- queue empty;
- outstanding 0;
- drop counter 0;
- imem_req 0;
- if_valid 0;
- if_pc and if_instr 0.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs perf_fetched (32) and perf_flushed (32):
- perf_fetched counts queue pops;
- perf_flushed counts redirect cycles;
- both zeroed by rst, wrapping at 2^32.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-031 The shared package cpu_pkg SHALL hold fetch_entry_t {pc, instr}, the fetch state enum and RESET_PC's default constant.
REQ-032 Queue storage SHALL be a sub-module fetch_queue (parameterised depth, push/pop/flush, count output).

Verification
REQ-033 Reset with RESET_PC=0, gnt=1, rvalid one cycle after grant, id_ready=1 -> BOOT 1 cycle; addrs 0,4,8...; if_pc 0 then 4 on consecutive cycles.
REQ-034 id_ready=0, memory always ready -> exactly 2 grants, queue full, imem_req low; release id_ready -> pops 0,4 and fetching resumes at 8.
REQ-035 Two requests outstanding, redirect_pc=32'h100 -> DRAIN; both stale responses dropped; next request address 32'h100; if_pc 32'h100 first.
REQ-036 Redirect in the same cycle as a grant and an rvalid -> drop counter = outstanding+1-1; no stale instruction ever appears on if_valid.
REQ-037 redirect_pc=32'hFFFF_FFFE -> fetch at 32'hFFFF_FFFC, then 32'h0000_0000.
REQ-038 rst asserted with outstanding=2 -> late rvalids ignored; first if_pc RESET_PC; perf counters 0 when FETCH_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch entry type, fetch state encoding and reset pc constant
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch queue of {pc, instr} entries with push/pop/flush and count
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  fetch_entry_t                 i_push_data,
   input  logic                         i_pop,
   output fetch_entry_t                 o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           w_empty;
   logic           w_do_push;
   logic           w_do_pop;

   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !w_empty;
   // a full queue still takes a push when the head leaves in the same cycle
   assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush && !rst) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with redirect drain; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   fetch_state_t  r_state;
   fetch_state_t  w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop;

   logic [CW-1:0] w_q_count;
   logic          w_q_empty;
   fetch_entry_t  w_q_head;
   fetch_entry_t  w_push_data;
   logic [CW:0]   w_inflight;
   logic [CW-1:0] w_redirect_out;
   logic          w_grant;
   logic          w_rsp;
   logic          w_push;
   logic          w_drop_rsp;
   logic          w_pop;

   assign w_inflight = {1'b0, w_q_count} + {1'b0, r_outstanding};
   assign imem_req   = (r_state == ST_RUN) && (w_inflight < (CW+1)'(QUEUE_DEPTH));
   assign imem_addr  = r_fetch_pc;
   assign w_grant    = imem_req && imem_gnt;

   // a beat with nothing outstanding belongs to a request abandoned by reset
   assign w_rsp      = imem_rvalid && (r_outstanding != '0);
   assign w_push     = w_rsp && !redirect_valid && (r_drop == '0);
   assign w_drop_rsp = w_rsp && !redirect_valid && (r_drop != '0);

   // out+grant never exceeds QUEUE_DEPTH, so CW bits suffice
   assign w_redirect_out = r_outstanding + CW'(w_grant) - CW'(w_rsp);

   assign w_q_empty  = (w_q_count == '0);
   assign if_valid   = !w_q_empty && !redirect_valid;
   assign w_pop      = if_valid && id_ready;
   assign if_pc      = w_q_head.pc;
   assign if_instr   = w_q_head.instr;

   // non-dropped responses arrive in order starting at the last redirect target
   assign w_push_data = '{pc: r_resp_pc, instr: imem_rdata};

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_q_head),
      .o_count     (w_q_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (redirect_valid && (w_redirect_out != '0)) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (redirect_valid) begin
               w_state_nxt = (w_redirect_out != '0) ? ST_DRAIN : ST_RUN;
            end else if (r_drop == '0) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_BOOT;
         r_fetch_pc    <= word_align(RESET_PC);
         r_resp_pc     <= word_align(RESET_PC);
         r_outstanding <= '0;
         r_drop        <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect_valid) begin
            r_fetch_pc    <= word_align(redirect_pc);
            r_resp_pc     <= word_align(redirect_pc);
            r_outstanding <= w_redirect_out;
            r_drop        <= w_redirect_out;
         end else begin
            if (w_grant)    r_fetch_pc <= pc_plus4(r_fetch_pc);
            if (w_push)     r_resp_pc  <= pc_plus4(r_resp_pc);
            if (w_drop_rsp) r_drop     <= r_drop - CW'(1);
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetched <= '0;
         r_perf_flushed <= '0;
      end else begin
         if (w_pop)          r_perf_fetched <= r_perf_fetched + 32'd1;
         if (redirect_valid) r_perf_flushed <= r_perf_flushed + 32'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif

endmodule
